// File: rtl/rv32i_types.sv
// Shared RV32I opcode set, decode constants and source-operand usage helpers.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      op_jalr, op_br, op_load, op_store, op_imm, op_reg: uses_rs1 = 1'b1;
      default:                                           uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      op_br, op_store, op_reg: uses_rs2 = 1'b1;
      default:                 uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      op_lui, op_auipc, op_jal, op_jalr, op_br,
      op_load, op_store, op_imm, op_reg, op_csr: is_legal = 1'b1;
      default:                                   is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ir_comb.sv
// Combinational RV32I field and immediate extraction from an instruction word.
module ir_comb (
  input  logic [31:0] ir_i,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] i_imm_o,
  output logic [31:0] s_imm_o,
  output logic [31:0] b_imm_o,
  output logic [31:0] u_imm_o,
  output logic [31:0] j_imm_o
);

  assign opcode_o = ir_i[6:0];
  assign rd_o     = ir_i[11:7];
  assign funct3_o = ir_i[14:12];
  assign rs1_o    = ir_i[19:15];
  assign rs2_o    = ir_i[24:20];
  assign funct7_o = ir_i[31:25];

  assign i_imm_o = {{21{ir_i[31]}}, ir_i[30:20]};
  assign s_imm_o = {{21{ir_i[31]}}, ir_i[30:25], ir_i[11:7]};
  assign b_imm_o = {{20{ir_i[31]}}, ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
  assign u_imm_o = {ir_i[31:12], 12'h000};
  assign j_imm_o = {{12{ir_i[31]}}, ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage control: IF/ID and ID/EX registers, load-use bubbles, flush and freeze.
module id_stage_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_valid_i,
  input  logic [31:0]       if_instr_i,
  input  logic [31:0]       if_pc_i,
  output logic              if_ready_o,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  output logic              dx_valid_o,
  output logic [31:0]       dx_pc_o,
  output logic [6:0]        dx_opcode_o,
  output logic [2:0]        dx_funct3_o,
  output logic [6:0]        dx_funct7_o,
  output logic [4:0]        dx_rs1_o,
  output logic [4:0]        dx_rs2_o,
  output logic [4:0]        dx_rd_o,
  output logic [31:0]       dx_imm_o,
  output logic              dx_illegal_o,
  output logic [PERF_W-1:0] perf_bubbles_o
);

  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q, fd_pc_d;

  logic        dx_valid_q, dx_valid_d;
  logic [31:0] dx_pc_q, dx_pc_d, dx_imm_q, dx_imm_d;
  logic [6:0]  dx_opcode_q, dx_opcode_d, dx_funct7_q, dx_funct7_d;
  logic [2:0]  dx_funct3_q, dx_funct3_d;
  logic [4:0]  dx_rs1_q, dx_rs1_d, dx_rs2_q, dx_rs2_d, dx_rd_q, dx_rd_d;
  logic        dx_illegal_q, dx_illegal_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, imm;
  logic        hazard;

  ir_comb u_ir_comb (
    .ir_i     (fd_instr_q),
    .opcode_o (opcode),
    .funct3_o (funct3),
    .funct7_o (funct7),
    .rs1_o    (rs1),
    .rs2_o    (rs2),
    .rd_o     (rd),
    .i_imm_o  (i_imm),
    .s_imm_o  (s_imm),
    .b_imm_o  (b_imm),
    .u_imm_o  (u_imm),
    .j_imm_o  (j_imm)
  );

  always_comb begin
    case (opcode)
      op_jalr, op_load, op_imm: imm = i_imm;
      op_store:                 imm = s_imm;
      op_br:                    imm = b_imm;
      op_lui, op_auipc:         imm = u_imm;
      op_jal:                   imm = j_imm;
      default:                  imm = 32'h0;
    endcase
  end

  // x0 never carries a real dependency, so rd==0 loads are excluded.
  assign hazard = fd_valid_q && dx_valid_q && (dx_opcode_q == op_load) && (dx_rd_q != 5'd0) &&
                  ((uses_rs1(opcode) && (rs1 == dx_rd_q)) ||
                   (uses_rs2(opcode) && (rs2 == dx_rd_q)));

  assign if_ready_o = !mem_stall_i && !hazard;

  always_comb begin
    fd_valid_d   = fd_valid_q;
    fd_instr_d   = fd_instr_q;
    fd_pc_d      = fd_pc_q;
    dx_valid_d   = dx_valid_q;
    dx_pc_d      = dx_pc_q;
    dx_opcode_d  = dx_opcode_q;
    dx_funct3_d  = dx_funct3_q;
    dx_funct7_d  = dx_funct7_q;
    dx_rs1_d     = dx_rs1_q;
    dx_rs2_d     = dx_rs2_q;
    dx_rd_d      = dx_rd_q;
    dx_imm_d     = dx_imm_q;
    dx_illegal_d = dx_illegal_q;
    perf_d       = perf_q;
    if (mem_stall_i) begin
      // Freeze everything; EX keeps flush asserted until the stall clears.
    end else if (flush_i) begin
      fd_valid_d = 1'b0;
      fd_instr_d = NOP_INSTR;
      dx_valid_d = 1'b0;
    end else if (hazard) begin
      dx_valid_d = 1'b0;
      if (perf_q != {PERF_W{1'b1}}) perf_d = perf_q + PERF_W'(1);
    end else begin
      fd_valid_d   = if_valid_i;
      fd_instr_d   = if_instr_i;
      fd_pc_d      = if_pc_i;
      dx_valid_d   = fd_valid_q;
      dx_pc_d      = fd_pc_q;
      dx_opcode_d  = opcode;
      dx_funct3_d  = funct3;
      dx_funct7_d  = funct7;
      dx_rs1_d     = rs1;
      dx_rs2_d     = rs2;
      dx_rd_d      = rd;
      dx_imm_d     = imm;
      dx_illegal_d = !is_legal(opcode);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fd_valid_q   <= 1'b0;
      fd_instr_q   <= NOP_INSTR;
      fd_pc_q      <= 32'h0;
      dx_valid_q   <= 1'b0;
      dx_pc_q      <= 32'h0;
      dx_opcode_q  <= 7'h0;
      dx_funct3_q  <= 3'h0;
      dx_funct7_q  <= 7'h0;
      dx_rs1_q     <= 5'h0;
      dx_rs2_q     <= 5'h0;
      dx_rd_q      <= 5'h0;
      dx_imm_q     <= 32'h0;
      dx_illegal_q <= 1'b0;
      perf_q       <= '0;
    end else begin
      fd_valid_q   <= fd_valid_d;
      fd_instr_q   <= fd_instr_d;
      fd_pc_q      <= fd_pc_d;
      dx_valid_q   <= dx_valid_d;
      dx_pc_q      <= dx_pc_d;
      dx_opcode_q  <= dx_opcode_d;
      dx_funct3_q  <= dx_funct3_d;
      dx_funct7_q  <= dx_funct7_d;
      dx_rs1_q     <= dx_rs1_d;
      dx_rs2_q     <= dx_rs2_d;
      dx_rd_q      <= dx_rd_d;
      dx_imm_q     <= dx_imm_d;
      dx_illegal_q <= dx_illegal_d;
      perf_q       <= perf_d;
    end
  end

  assign dx_valid_o     = dx_valid_q;
  assign dx_pc_o        = dx_pc_q;
  assign dx_opcode_o    = dx_opcode_q;
  assign dx_funct3_o    = dx_funct3_q;
  assign dx_funct7_o    = dx_funct7_q;
  assign dx_rs1_o       = dx_rs1_q;
  assign dx_rs2_o       = dx_rs2_q;
  assign dx_rd_o        = dx_rd_q;
  assign dx_imm_o       = dx_imm_q;
  assign dx_illegal_o   = dx_illegal_q;
  assign perf_bubbles_o = perf_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: reset, decode, load-use bubble, x0, stall/flush, immediates.
module tb_id_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst, if_valid, mem_stall, flush;
  logic [31:0] if_instr, if_pc;
  logic        if_ready, dx_valid, dx_illegal;
  logic [31:0] dx_pc, dx_imm;
  logic [6:0]  dx_opcode, dx_funct7;
  logic [2:0]  dx_funct3;
  logic [4:0]  dx_rs1, dx_rs2, dx_rd;
  logic [15:0] perf_bubbles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_ctrl #(.PERF_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .if_valid_i     (if_valid),
    .if_instr_i     (if_instr),
    .if_pc_i        (if_pc),
    .if_ready_o     (if_ready),
    .mem_stall_i    (mem_stall),
    .flush_i        (flush),
    .dx_valid_o     (dx_valid),
    .dx_pc_o        (dx_pc),
    .dx_opcode_o    (dx_opcode),
    .dx_funct3_o    (dx_funct3),
    .dx_funct7_o    (dx_funct7),
    .dx_rs1_o       (dx_rs1),
    .dx_rs2_o       (dx_rs2),
    .dx_rd_o        (dx_rd),
    .dx_imm_o       (dx_imm),
    .dx_illegal_o   (dx_illegal),
    .perf_bubbles_o (perf_bubbles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one edge, then a bubble-free idle edge.
  task automatic fetch2(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    tick();
    if_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
    mem_stall = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_dx_valid", {31'h0, dx_valid}, 32'h0);
    chk("rst_if_ready", {31'h0, if_ready}, 32'h1);
    chk("rst_perf", {16'h0, perf_bubbles}, 32'h0);
    chk("rst_fd_instr", dut.fd_instr_q, 32'h0000_0013);
    chk("rst_dx_pc", dx_pc, 32'h0);

    // addi x1,x0,5
    fetch2(32'h0050_0093, 32'h60);
    chk("addi_valid", {31'h0, dx_valid}, 32'h1);
    chk("addi_opcode", {25'h0, dx_opcode}, 32'h13);
    chk("addi_rd", {27'h0, dx_rd}, 32'h1);
    chk("addi_imm", dx_imm, 32'h5);
    chk("addi_pc", dx_pc, 32'h60);
    chk("addi_illegal", {31'h0, dx_illegal}, 32'h0);

    // lw x2,0(x1) then add x3,x2,x1: one bubble
    if_valid = 1'b1; if_instr = 32'h0000_A103; if_pc = 32'h64;
    tick();
    if_instr = 32'h0011_01B3; if_pc = 32'h68;
    tick();
    #1;
    chk("lu_if_ready_low", {31'h0, if_ready}, 32'h0);
    chk("lu_dx_is_load", {25'h0, dx_opcode}, 32'h03);
    if_valid = 1'b0;
    tick();
    chk("lu_bubble", {31'h0, dx_valid}, 32'h0);
    chk("lu_perf", {16'h0, perf_bubbles}, 32'h1);
    chk("lu_if_ready_back", {31'h0, if_ready}, 32'h1);
    tick();
    chk("lu_add_valid", {31'h0, dx_valid}, 32'h1);
    chk("lu_add_opcode", {25'h0, dx_opcode}, 32'h33);
    chk("lu_add_rd", {27'h0, dx_rd}, 32'h3);
    chk("lu_add_pc", dx_pc, 32'h68);

    // lw x0,0(x1) then add x3,x0,x0: no bubble
    if_valid = 1'b1; if_instr = 32'h0000_A003; if_pc = 32'h70;
    tick();
    if_instr = 32'h0000_01B3; if_pc = 32'h74;
    tick();
    #1;
    chk("x0_if_ready", {31'h0, if_ready}, 32'h1);
    if_valid = 1'b0;
    tick();
    chk("x0_add_valid", {31'h0, dx_valid}, 32'h1);
    chk("x0_add_pc", dx_pc, 32'h74);
    chk("x0_perf", {16'h0, perf_bubbles}, 32'h1);

    // Load-use under a 3-cycle stall, flush during and after it
    if_valid = 1'b1; if_instr = 32'h0000_A103; if_pc = 32'h80;
    tick();
    if_instr = 32'h0011_01B3; if_pc = 32'h84;
    tick();
    if_valid = 1'b0;
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      #1;
      chk("stall_if_ready", {31'h0, if_ready}, 32'h0);
      tick();
      chk("stall_dx_valid", {31'h0, dx_valid}, 32'h1);
      chk("stall_dx_opcode", {25'h0, dx_opcode}, 32'h03);
      chk("stall_dx_rd", {27'h0, dx_rd}, 32'h2);
      chk("stall_dx_pc", dx_pc, 32'h80);
      chk("stall_perf", {16'h0, perf_bubbles}, 32'h1);
    end
    mem_stall = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_dx_valid", {31'h0, dx_valid}, 32'h0);
    chk("flush_fd_valid", {31'h0, dut.fd_valid_q}, 32'h0);
    chk("flush_fd_instr", dut.fd_instr_q, 32'h0000_0013);
    chk("flush_perf_no_inc", {16'h0, perf_bubbles}, 32'h1);
    chk("flush_if_ready", {31'h0, if_ready}, 32'h1);

    // beq x0,x0,-4
    fetch2(32'hFE00_0EE3, 32'h90);
    chk("beq_valid", {31'h0, dx_valid}, 32'h1);
    chk("beq_opcode", {25'h0, dx_opcode}, 32'h63);
    chk("beq_imm", dx_imm, 32'hFFFF_FFFC);
    chk("beq_illegal", {31'h0, dx_illegal}, 32'h0);

    // lui x1,0x12345
    fetch2(32'h1234_50B7, 32'h94);
    chk("lui_imm", dx_imm, 32'h1234_5000);
    chk("lui_rd", {27'h0, dx_rd}, 32'h1);

    // Unknown opcode
    fetch2(32'h0000_007F, 32'h98);
    chk("ill_valid", {31'h0, dx_valid}, 32'h1);
    chk("ill_flag", {31'h0, dx_illegal}, 32'h1);
    chk("ill_imm", dx_imm, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
